// File: rtl/lspc_pkg.sv
// Shared types and constants for the LSPC VRAM CPU access port.
// FSM state encoding, pointer wrap mask and bank-select bit index.
package lspc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WR,
    WR,
    ACK,
    INC,
    WAIT_RD,
    RD
  } state_t;

  localparam logic [14:0] PTR_WRAP_MASK = 15'h7FFF;
  localparam int          BANK_BIT      = 15;

endpackage

// File: rtl/lspc_vram_ptr.sv
// VRAM pointer register with modulo auto-increment.
// A load always beats an increment in the same cycle.
module lspc_vram_ptr
  import lspc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        inc,
  input  logic [15:0] load_val,
  input  logic [15:0] mod,
  output logic [15:0] ptr
);

  logic [14:0] sum;
  logic        unused_mod;

  assign sum        = (ptr[14:0] + mod[14:0]) & PTR_WRAP_MASK;
  assign unused_mod = mod[15];

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (load) begin
      ptr <= load_val;
    end else if (inc) begin
      // bank bit is sticky; only the low 15 bits wrap
      ptr <= {ptr[BANK_BIT], sum};
    end
  end

endmodule

// File: rtl/lspc_vram_cpu_port.sv
// LSPC CPU-side VRAM port: address load, slot-timed write/read, auto-inc.
// Define LSPC_VRAM_READ_PREFETCH_EN to re-read VRAM after every increment.
module lspc_vram_cpu_port
  import lspc_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        WR_VRAM_ADDR,
  input  logic [15:0] REG_VRAMADDR,
  input  logic [15:0] REG_VRAMMOD,
  input  logic [15:0] REG_VRAMRW,
  input  logic        nVRAM_WRITE_REQ,
  input  logic        CPU_SLOT,
  input  logic [15:0] SVRAM_RD,
  input  logic [15:0] FVRAM_RD,
  output logic [15:0] VRAM_ADDR,
  output logic [15:0] VRAM_DATA_OUT,
  output logic        VRAM_WE,
  output logic        VRAM_WRITE_ACK,
  output logic [15:0] VRAM_LOW_READ,
  output logic [15:0] VRAM_HIGH_READ
);

  state_t      state;
  state_t      state_n;
  logic        wr_q;
  logic        load;
  logic        rd_pend;
  logic [15:0] ptr;

`ifdef LSPC_VRAM_READ_PREFETCH_EN
  localparam bit PREFETCH = 1'b1;
`else
  localparam bit PREFETCH = 1'b0;
`endif

  // strobe history tracks input during reset so no edge survives it
  always_ff @(posedge CLK) begin
    wr_q <= WR_VRAM_ADDR;
    if (RESET) begin
      load <= 1'b0;
    end else begin
      load <= WR_VRAM_ADDR & ~wr_q;
    end
  end

  lspc_vram_ptr u_ptr (
    .clk      (CLK),
    .reset    (RESET),
    .load     (load),
    .inc      (state == INC),
    .load_val (REG_VRAMADDR),
    .mod      (REG_VRAMMOD),
    .ptr      (ptr)
  );

  assign VRAM_ADDR = ptr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (!nVRAM_WRITE_REQ) begin
          state_n = WAIT_WR;
        end else if (rd_pend) begin
          state_n = WAIT_RD;
        end
      end
      WAIT_WR: if (CPU_SLOT) state_n = WR;
      WR:      state_n = ACK;
      ACK:     if (nVRAM_WRITE_REQ) state_n = INC;
      INC:     state_n = IDLE;
      WAIT_RD: if (CPU_SLOT) state_n = RD;
      RD:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      VRAM_WE        <= 1'b0;
      VRAM_WRITE_ACK <= 1'b0;
      VRAM_DATA_OUT  <= '0;
    end else begin
      VRAM_WE        <= (state_n == WR);
      VRAM_WRITE_ACK <= (state_n == ACK);
      if (state_n == WR) begin
        VRAM_DATA_OUT <= REG_VRAMRW;
      end
    end
  end

  // a load during RD keeps the request alive so the read repeats
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rd_pend <= 1'b0;
    end else if (load) begin
      rd_pend <= 1'b1;
    end else if (state == INC && PREFETCH) begin
      rd_pend <= 1'b1;
    end else if (state == RD) begin
      rd_pend <= 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      VRAM_LOW_READ  <= '0;
      VRAM_HIGH_READ <= '0;
    end else if (state == RD) begin
      if (ptr[BANK_BIT]) begin
        VRAM_HIGH_READ <= FVRAM_RD;
      end else begin
        VRAM_LOW_READ <= SVRAM_RD;
      end
    end
  end

endmodule

// File: tb/tb_lspc_vram_cpu_port.sv
// Randomized self-checking bench for lspc_vram_cpu_port.
// Transaction-level model: pointer, bank read-back and write events.
module tb_lspc_vram_cpu_port;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        WR_VRAM_ADDR;
  logic [15:0] REG_VRAMADDR;
  logic [15:0] REG_VRAMMOD;
  logic [15:0] REG_VRAMRW;
  logic        nVRAM_WRITE_REQ;
  logic        CPU_SLOT;
  logic [15:0] SVRAM_RD;
  logic [15:0] FVRAM_RD;
  logic [15:0] VRAM_ADDR;
  logic [15:0] VRAM_DATA_OUT;
  logic        VRAM_WE;
  logic        VRAM_WRITE_ACK;
  logic [15:0] VRAM_LOW_READ;
  logic [15:0] VRAM_HIGH_READ;

`ifdef LSPC_VRAM_READ_PREFETCH_EN
  localparam bit PF = 1'b1;
`else
  localparam bit PF = 1'b0;
`endif

  lspc_vram_cpu_port dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .WR_VRAM_ADDR    (WR_VRAM_ADDR),
    .REG_VRAMADDR    (REG_VRAMADDR),
    .REG_VRAMMOD     (REG_VRAMMOD),
    .REG_VRAMRW      (REG_VRAMRW),
    .nVRAM_WRITE_REQ (nVRAM_WRITE_REQ),
    .CPU_SLOT        (CPU_SLOT),
    .SVRAM_RD        (SVRAM_RD),
    .FVRAM_RD        (FVRAM_RD),
    .VRAM_ADDR       (VRAM_ADDR),
    .VRAM_DATA_OUT   (VRAM_DATA_OUT),
    .VRAM_WE         (VRAM_WE),
    .VRAM_WRITE_ACK  (VRAM_WRITE_ACK),
    .VRAM_LOW_READ   (VRAM_LOW_READ),
    .VRAM_HIGH_READ  (VRAM_HIGH_READ)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0] m_ptr;
  logic [15:0] m_low;
  logic [15:0] m_high;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // active-low strobe: the pointer takes the value on its release
  task automatic do_load(input logic [15:0] a);
    REG_VRAMADDR = a;
    WR_VRAM_ADDR = 1'b0;
    tick();
    WR_VRAM_ADDR = 1'b1;
    tick();
    tick();
    m_ptr = a;
    check("load_ptr", {16'h0, VRAM_ADDR}, {16'h0, m_ptr});
  endtask

  task automatic do_read(input logic [15:0] s, input logic [15:0] f);
    SVRAM_RD = s;
    FVRAM_RD = f;
    tick();
    repeat ($urandom_range(0, 3)) tick();
    CPU_SLOT = 1'b1;
    tick();
    CPU_SLOT = 1'b0;
    check("rd_addr", {16'h0, VRAM_ADDR}, {16'h0, m_ptr});
    check("rd_we", {31'h0, VRAM_WE}, 32'h0);
    tick();
    if (m_ptr >= 16'h8000) m_high = f;
    else m_low = s;
    check("rd_low", {16'h0, VRAM_LOW_READ}, {16'h0, m_low});
    check("rd_high", {16'h0, VRAM_HIGH_READ}, {16'h0, m_high});
  endtask

  task automatic do_write(input logic [15:0] d, input logic [15:0] mod,
                          input int gap, input bit ld_inc,
                          input logic [15:0] la, input bit rst_ack);
    int we_seen;
    int hold;
    we_seen = 0;
    REG_VRAMRW = d;
    REG_VRAMMOD = mod;
    nVRAM_WRITE_REQ = 1'b0;
    repeat (gap) begin
      tick();
      if (VRAM_WE) we_seen++;
    end
    check("wr_no_slot_no_we", we_seen, 0);
    CPU_SLOT = 1'b1;
    tick();
    CPU_SLOT = 1'b0;
    check("wr_we", {31'h0, VRAM_WE}, 32'h1);
    check("wr_addr", {16'h0, VRAM_ADDR}, {16'h0, m_ptr});
    check("wr_data", {16'h0, VRAM_DATA_OUT}, {16'h0, d});
    check("wr_ack_not_yet", {31'h0, VRAM_WRITE_ACK}, 32'h0);
    tick();
    check("wr_we_one_cycle", {31'h0, VRAM_WE}, 32'h0);
    check("wr_ack_rise", {31'h0, VRAM_WRITE_ACK}, 32'h1);
    if (rst_ack) begin
      RESET = 1'b1;
      tick();
      check("rst_ack_low", {31'h0, VRAM_WRITE_ACK}, 32'h0);
      check("rst_ptr", {16'h0, VRAM_ADDR}, 32'h0);
      check("rst_data", {16'h0, VRAM_DATA_OUT}, 32'h0);
      RESET = 1'b0;
      nVRAM_WRITE_REQ = 1'b1;
      m_ptr = '0;
      m_low = '0;
      m_high = '0;
      we_seen = 0;
      repeat (6) begin
        CPU_SLOT = 1'b1;
        tick();
        if (VRAM_WE || VRAM_WRITE_ACK) we_seen++;
      end
      CPU_SLOT = 1'b0;
      check("rst_no_more_we", we_seen, 0);
      check("rst_low", {16'h0, VRAM_LOW_READ}, 32'h0);
      check("rst_high", {16'h0, VRAM_HIGH_READ}, 32'h0);
      return;
    end
    hold = $urandom_range(0, 3);
    repeat (hold) tick();
    check("wr_ack_hold", {31'h0, VRAM_WRITE_ACK}, 32'h1);
    if (ld_inc) begin
      WR_VRAM_ADDR = 1'b0;
      REG_VRAMADDR = la;
      tick();
      WR_VRAM_ADDR = 1'b1;
    end
    nVRAM_WRITE_REQ = 1'b1;
    tick();
    check("wr_ack_drop", {31'h0, VRAM_WRITE_ACK}, 32'h0);
    tick();
    if (ld_inc) m_ptr = la;
    else m_ptr = (m_ptr & 16'h8000) | ((m_ptr + mod) & 16'h7FFF);
    check("wr_ptr_next", {16'h0, VRAM_ADDR}, {16'h0, m_ptr});
    if (ld_inc || PF) do_read(16'($urandom), 16'($urandom));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b1;
    WR_VRAM_ADDR = 1'b1;
    REG_VRAMADDR = 16'h5555;
    REG_VRAMMOD = 16'h0;
    REG_VRAMRW = 16'h0;
    nVRAM_WRITE_REQ = 1'b1;
    CPU_SLOT = 1'b0;
    SVRAM_RD = 16'h0;
    FVRAM_RD = 16'h0;
    m_ptr = '0;
    m_low = '0;
    m_high = '0;
    tick();
    WR_VRAM_ADDR = 1'b0;
    tick();
    WR_VRAM_ADDR = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    check("reset_addr", {16'h0, VRAM_ADDR}, 32'h0);
    check("reset_we", {31'h0, VRAM_WE}, 32'h0);
    check("reset_ack", {31'h0, VRAM_WRITE_ACK}, 32'h0);
    check("reset_dout", {16'h0, VRAM_DATA_OUT}, 32'h0);
    check("reset_low", {16'h0, VRAM_LOW_READ}, 32'h0);
    check("reset_high", {16'h0, VRAM_HIGH_READ}, 32'h0);
    tick();
    tick();
    check("no_load_from_reset", {16'h0, VRAM_ADDR}, 32'h0);

    do_load(16'h1234);
    do_read(16'hBEEF, 16'h0F0F);
    check("c033_low", {16'h0, VRAM_LOW_READ}, 32'hBEEF);

    do_load(16'h7FFF);
    do_read(16'h1111, 16'h2222);
    do_write(16'hA5A5, 16'h0002, 1, 1'b0, 16'h0, 1'b0);
    check("c034_wrap", {16'h0, VRAM_ADDR}, 32'h0001);

    do_load(16'h8400);
    do_read(16'h3333, 16'h4444);
    do_write(16'h5A5A, 16'h0001, 2, 1'b0, 16'h0, 1'b0);
    check("c035_bank", {16'h0, VRAM_ADDR}, 32'h8401);

    do_write(16'hC0DE, 16'h0000, 3, 1'b0, 16'h0, 1'b0);
    check("mod0_ptr", {16'h0, VRAM_ADDR}, 32'h8401);

    do_write(16'h1357, 16'h0003, 100, 1'b0, 16'h0, 1'b0);

    do_write(16'h2468, 16'h0005, 2, 1'b1, 16'h2345, 1'b0);
    check("c037_load_wins", {16'h0, VRAM_ADDR}, 32'h2345);

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_load(16'($urandom));
        do_read(16'($urandom), 16'($urandom));
      end else begin
        logic [15:0] md;
        md = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        do_write(16'($urandom), md, $urandom_range(1, 6), 1'b0, 16'h0, 1'b0);
      end
    end

    do_load(16'h4321);
    do_read(16'h6666, 16'h7777);
    do_write(16'h9999, 16'h0010, 2, 1'b0, 16'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
